// File: rtl/scene_state_gen.sv
// scene_state_gen: producer of the VGA scene descriptor (four scrolling blocks plus a jumping square).
// Optional feature: define SCENE_SPEEDUP_EN for a score-driven scroll speed-up.

`ifndef SHAPE_ENCODE_LENGTH
`define SHAPE_ENCODE_LENGTH 3
`endif
`ifndef COORDINATE_LENGTH
`define COORDINATE_LENGTH 11
`endif
`ifndef SQUARE_SIZE_LENGTH
`define SQUARE_SIZE_LENGTH 6
`endif

module scene_state_gen #(
  parameter int SCREEN_W      = 640,
  parameter int BLOCK_SPACING = 160,
  parameter int SCROLL_STEP   = 4,
  parameter int GROUND_Y      = 400,
  parameter int JUMP_V0       = 12,
  parameter int GRAVITY       = 1,
  parameter int SQ_SIZE_INIT  = 32
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              FRAME_TICK,
  input  logic                              START,
  input  logic                              JUMP,
  input  logic                              HIT,
  output logic [4*`SHAPE_ENCODE_LENGTH-1:0] BLOCK_SHAPE,
  output logic [4*`COORDINATE_LENGTH-1:0]   BLOCK_START_X,
  output logic [`COORDINATE_LENGTH-1:0]     SQUARE_START_Y,
  output logic [`SQUARE_SIZE_LENGTH-1:0]    SQUARE_SIZE,
  output logic [15:0]                       SCORE,
  output logic                              GAME_OVER,
  output logic                              BUSY
);

  localparam int SW  = `SHAPE_ENCODE_LENGTH;
  localparam int CW  = `COORDINATE_LENGTH;
  localparam int ZW  = `SQUARE_SIZE_LENGTH;
  localparam int VW  = CW + 2;
  localparam logic [CW-1:0]        GROUND_TOP = CW'(GROUND_Y - SQ_SIZE_INIT);
  localparam logic [CW-1:0]        WRAP_DIST  = CW'(4 * BLOCK_SPACING);
  localparam logic signed [VW-1:0] V0         = VW'(JUMP_V0);
  localparam logic signed [VW-1:0] GRAV       = VW'(GRAVITY);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_B1, S_B2, S_B3, S_B4, S_SQ, S_OVER
  } state_t;

  state_t               state_q, state_d;
  logic [3:0][CW-1:0]   x_q, x_d;
  logic [3:0][SW-1:0]   shape_q, shape_d;
  logic [CW-1:0]        y_q, y_d;
  logic signed [VW-1:0] vel_q, vel_d;
  logic [15:0]          score_q, score_d;
  logic                 pend_q, pend_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic                 busy_q, busy_d;
  logic                 over_q, over_d;

  logic                 running, hit_now, reinit, grounded, jump_now;
  logic [CW-1:0]        step_cur;
  logic [1:0]           blk;
  logic signed [VW-1:0] vel_eff, ny;

  assign running  = (state_q != S_IDLE) && (state_q != S_OVER);
  assign hit_now  = running && HIT;
  assign reinit   = START && !hit_now;
  assign grounded = (y_q == GROUND_TOP) && (vel_q == '0);
  assign jump_now = pend_q || (JUMP && grounded);

`ifdef SCENE_SPEEDUP_EN
  // Step is latched when a sequence starts so all four blocks move by the same amount.
  logic [CW-1:0] step_q, step_d, step_new;
  always_comb begin
    step_new = CW'(SCROLL_STEP) + CW'(score_q[15:4]);
    if (score_q[15:4] >= 12'(SCROLL_STEP)) step_new = CW'(2 * SCROLL_STEP);
  end
  assign step_cur = step_q;
`else
  assign step_cur = CW'(SCROLL_STEP);
`endif

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // HIT wins over START; START from any state (re)starts the game.
  always_comb begin
    state_d = state_q;
    if (hit_now) begin
      state_d = S_OVER;
    end else if (START) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN:   if (FRAME_TICK) state_d = S_B1;
        S_B1:    state_d = S_B2;
        S_B2:    state_d = S_B3;
        S_B3:    state_d = S_B4;
        S_B4:    state_d = S_SQ;
        S_SQ:    state_d = S_RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    x_d      = x_q;
    shape_d  = shape_q;
    y_d      = y_q;
    vel_d    = vel_q;
    score_d  = score_q;
    pend_d   = pend_q;
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    busy_d   = (state_d == S_B1) || (state_d == S_B2) || (state_d == S_B3) ||
               (state_d == S_B4) || (state_d == S_SQ);
    over_d   = (state_d == S_OVER);
    blk      = 2'(3'(state_q) - 3'(S_B1));
    vel_eff  = jump_now ? V0 : vel_q;
    ny       = $signed({2'b00, y_q}) - vel_eff;
`ifdef SCENE_SPEEDUP_EN
    step_d   = step_q;
`endif
    if (reinit) begin
      for (int i = 0; i < 4; i++) begin
        x_d[i]     = CW'(SCREEN_W + i * BLOCK_SPACING);
        shape_d[i] = '0;
      end
      y_d     = GROUND_TOP;
      vel_d   = '0;
      score_d = '0;
      pend_d  = 1'b0;
`ifdef SCENE_SPEEDUP_EN
      step_d  = CW'(SCROLL_STEP);
`endif
    end else if (running && !HIT) begin
      pend_d = jump_now;
`ifdef SCENE_SPEEDUP_EN
      if (state_q == S_RUN && FRAME_TICK) step_d = step_new;
`endif
      case (state_q)
        S_B1, S_B2, S_B3, S_B4: begin
          if (x_q[blk] >= step_cur) begin
            x_d[blk] = x_q[blk] - step_cur;
          end else begin
            x_d[blk]     = x_q[blk] + WRAP_DIST - step_cur;
            shape_d[blk] = lfsr_q[SW-1:0];
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
          end
        end
        S_SQ: begin
          pend_d = 1'b0;
          if (ny >= $signed({2'b00, GROUND_TOP})) begin
            y_d   = GROUND_TOP;
            vel_d = '0;
          end else if (ny[VW-1]) begin
            y_d   = '0;
            vel_d = '0;
          end else begin
            y_d   = ny[CW-1:0];
            vel_d = vel_eff - GRAV;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        x_q[i]     <= CW'(SCREEN_W + i * BLOCK_SPACING);
        shape_q[i] <= '0;
      end
      y_q     <= GROUND_TOP;
      vel_q   <= '0;
      score_q <= '0;
      pend_q  <= 1'b0;
      lfsr_q  <= 8'hA5;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
`ifdef SCENE_SPEEDUP_EN
      step_q  <= CW'(SCROLL_STEP);
`endif
    end else begin
      x_q     <= x_d;
      shape_q <= shape_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      score_q <= score_d;
      pend_q  <= pend_d;
      lfsr_q  <= lfsr_d;
      busy_q  <= busy_d;
      over_q  <= over_d;
`ifdef SCENE_SPEEDUP_EN
      step_q  <= step_d;
`endif
    end
  end

  assign BLOCK_START_X  = {x_q[0], x_q[1], x_q[2], x_q[3]};
  assign BLOCK_SHAPE    = {shape_q[0], shape_q[1], shape_q[2], shape_q[3]};
  assign SQUARE_START_Y = y_q;
  assign SQUARE_SIZE    = ZW'(SQ_SIZE_INIT);
  assign SCORE          = score_q;
  assign GAME_OVER      = over_q;
  assign BUSY           = busy_q;

endmodule

// File: tb/tb_scene_state_gen.sv
// tb_scene_state_gen: randomized frame stimulus against a frame-level reference model with a scoreboard.
`timescale 1ns/1ps

`ifndef SHAPE_ENCODE_LENGTH
`define SHAPE_ENCODE_LENGTH 3
`endif
`ifndef COORDINATE_LENGTH
`define COORDINATE_LENGTH 11
`endif
`ifndef SQUARE_SIZE_LENGTH
`define SQUARE_SIZE_LENGTH 6
`endif

module tb_scene_state_gen;
  localparam int SW = `SHAPE_ENCODE_LENGTH;
  localparam int CW = `COORDINATE_LENGTH;
  localparam int ZW = `SQUARE_SIZE_LENGTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, frame_tick, start, jump, hit;
  logic [4*SW-1:0] block_shape;
  logic [4*CW-1:0] block_start_x;
  logic [CW-1:0]   square_start_y;
  logic [ZW-1:0]   square_size;
  logic [15:0]     score;
  logic            game_over, busy;

  scene_state_gen dut (
    .CLK(clk), .RST(rst), .FRAME_TICK(frame_tick), .START(start), .JUMP(jump), .HIT(hit),
    .BLOCK_SHAPE(block_shape), .BLOCK_START_X(block_start_x), .SQUARE_START_Y(square_start_y),
    .SQUARE_SIZE(square_size), .SCORE(score), .GAME_OVER(game_over), .BUSY(busy)
  );

  typedef struct packed {
    logic [4*CW-1:0] x;
    logic [4*SW-1:0] s;
    logic [15:0]     score;
    logic [CW-1:0]   y;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0, errors = 0;
  int mx[4], ms[4];
  int mscore, my, mvel;
  bit mpend, m_run;
  logic [7:0] mlfsr;
  int cyc = 0, last_tick = -100;
  bit sb_abort = 0;
  logic busy_prev = 1'b0;
  int busy_len = 0;
  logic [4*CW-1:0] x_rst;

  // Free-running pseudo-random source the model draws respawn shapes from.
  always @(posedge clk) begin
    if (rst) mlfsr <= 8'hA5;
    else     mlfsr <= {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_adv(input logic [7:0] l, input int n);
    logic [7:0] v;
    v = l;
    for (int k = 0; k < n; k++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  function automatic int cur_step();
`ifdef SCENE_SPEEDUP_EN
    return 4 + (((mscore >> 4) > 4) ? 4 : (mscore >> 4));
`else
    return 4;
`endif
  endfunction

  function automatic int blk_next(input int x, input int s);
    return (x < s) ? x + 640 - s : x - s;
  endfunction

  function automatic exp_t model_snapshot();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.x[(3-i)*CW +: CW] = CW'(mx[i]);
      e.s[(3-i)*SW +: SW] = SW'(ms[i]);
    end
    e.score = 16'(mscore);
    e.y     = CW'(my);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mx[i] = 640 + 160 * i;
      ms[i] = 0;
    end
    mscore = 0; my = 368; mvel = 0; mpend = 0; last_tick = cyc - 100;
  endtask

  // Whole-frame effect of one accepted tick.
  task automatic model_frame();
    int s, v, ny;
    logic [7:0] l;
    s = cur_step();
    for (int i = 0; i < 4; i++) begin
      l = lfsr_adv(mlfsr, i + 1);
      if (mx[i] < s) begin
        mx[i] = mx[i] + 640 - s;
        ms[i] = int'(l[SW-1:0]);
        if (mscore < 65535) mscore++;
      end else begin
        mx[i] = mx[i] - s;
      end
    end
    v = mpend ? 12 : mvel;
    mpend = 0;
    ny = my - v;
    if (ny >= 368)  begin my = 368; mvel = 0; end
    else if (ny < 0) begin my = 0;   mvel = 0; end
    else             begin my = ny;  mvel = v - 1; end
    sb_q.push_back(model_snapshot());
  endtask

  task automatic apply_stimulus(input bit t, input bit j, input bit st, input bit h);
    frame_tick = t; jump = j; start = st; hit = h;
    if (m_run && h) begin
      m_run = 0;
    end else if (st) begin
      model_reset();
      m_run = 1;
    end else if (m_run) begin
      if (j && (cyc - last_tick > 5) && my == 368 && mvel == 0) mpend = 1;
      if (t && (cyc - last_tick > 5)) begin
        last_tick = cyc;
        model_frame();
      end
    end
    @(negedge clk);
    cyc++;
    frame_tick = 0; jump = 0; start = 0; hit = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(0, 0, 0, 0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() > 0 && guard < 30) begin
      idle(1);
      guard++;
    end
    check_output("sb_drain", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic run_frames(input int n);
    int r;
    for (int f = 0; f < n; f++) begin
      r = $urandom_range(0, 9);
      apply_stimulus(1, r == 0, 0, 0);
      if (r == 1) begin
        idle(1);
        apply_stimulus(1, 0, 0, 0);
        idle(4);
      end else begin
        idle(5);
      end
      if (r == 2) apply_stimulus(0, 1, 0, 0);
      else        idle(1);
      idle($urandom_range(0, 3));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_x"},     block_start_x, x_rst);
    check_output({tag, "_shape"}, block_shape, 64'd0);
    check_output({tag, "_y"},     square_start_y, 64'd368);
    check_output({tag, "_score"}, score, 64'd0);
    check_output({tag, "_over"},  game_over, 64'd0);
    check_output({tag, "_busy"},  busy, 64'd0);
  endtask

  // Monitor: each completed sequence is compared against the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      busy_len++;
    end else if (busy_prev === 1'b1) begin
      if (sb_abort) begin
        sb_abort = 0;
      end else begin
        check_output("busy_len", 64'(busy_len), 64'd5);
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL sb_empty: got sequence end expected none at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          check_output("frame_x",     block_start_x, e.x);
          check_output("frame_shape", block_shape, e.s);
          check_output("frame_score", score, e.score);
          check_output("frame_y",     square_start_y, e.y);
        end
      end
      busy_len = 0;
    end
    busy_prev = busy;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4*CW-1:0] pre_x, snap_x;
    logic [4*SW-1:0] snap_s;
    logic [CW-1:0]   snap_y;
    logic [15:0]     snap_score;
    int              exp_b1;

    x_rst = {11'd640, 11'd800, 11'd960, 11'd1120};
    rst = 1; frame_tick = 0; start = 0; jump = 0; hit = 0;
    m_run = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;

    check_reset_values("reset");
    check_output("sq_size", square_size, 64'd32);

    apply_stimulus(1, 1, 0, 0);
    idle(6);
    check_output("idle_busy", busy, 64'd0);
    check_output("idle_x", block_start_x, x_rst);

    apply_stimulus(0, 0, 1, 0);
    check_output("start_over", game_over, 64'd0);
    run_frames(700);
    drain();

    $display("[TB] hit test, score %0d", mscore);
    m_run = 0;
    sb_abort = 1;
    pre_x = block_start_x;
    exp_b1 = blk_next(mx[0], cur_step());
    apply_stimulus(1, 0, 0, 0);
    idle(1);
    apply_stimulus(0, 0, 0, 1);
    check_output("hit_over", game_over, 64'd1);
    check_output("hit_busy", busy, 64'd0);
    check_output("hit_b1_written", block_start_x[4*CW-1 -: CW], 64'(exp_b1));
    check_output("hit_b34_kept", block_start_x[2*CW-1:0], pre_x[2*CW-1:0]);
    snap_x = block_start_x; snap_s = block_shape; snap_y = square_start_y; snap_score = score;
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1, 1, 0, 0);
      idle(7);
      check_output("over_x",     block_start_x, snap_x);
      check_output("over_shape", block_shape, snap_s);
      check_output("over_y",     square_start_y, snap_y);
      check_output("over_score", score, snap_score);
      check_output("over_flag",  game_over, 64'd1);
    end

    apply_stimulus(0, 0, 1, 0);
    check_reset_values("restart");
    run_frames(20);
    drain();

    m_run = 0;
    sb_abort = 1;
    apply_stimulus(1, 0, 0, 0);
    idle(1);
    rst = 1;
    @(negedge clk);
    cyc++;
    rst = 0;
    model_reset();
    check_reset_values("midrst");

    apply_stimulus(0, 0, 1, 0);
    run_frames(30);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
